audio_slot_scheduler: RTL
=========================

// Module: audio_slot_scheduler
// PURPOSE
//  Programmable time-slot scheduler for the shared audio DAC pair. Replaces the fixed 4-phase source
//  rotation with per-source slot weights, so the CPU can rebalance or mute the speaker, SpecDrum and
//  PSG A/B/C. Weights are written through a small config port. Registered 8-bit L/R mix feeds the dacs.
// PARAMETERS
//  WDEF   4'd1   reset weight of every source (1,1,1,1 = plain 4-phase rotation)
// PORTS
//  clock     in   1   system clock, single clock domain
//  reset     in   1   synchronous, active-high reset
//  speaker   in   1   beeper bit
//  specdrum  in   8   SpecDrum sample
//  a         in   8   PSG channel A
//  b         in   8   PSG channel B
//  c         in   8   PSG channel C
//  cfgWe     in   1   config write strobe, one clock per write
//  cfgA      in   2   config register index = source number (0 spk, 1 drum, 2 A/B, 3 C)
//  cfgD      in   8   write data; [3:0] weight, [7:4] ignored
//  cfgQ      out  8   {4'h0, shadow weight[cfgA]}, combinational readback
//  lmix      out  8   left DAC input, registered
//  rmix      out  8   right DAC input, registered
//  frame     out  1   one-clock pulse on every frame commit
// BEHAVIOUR
//  - State: cur[1:0] active source; cnt[3:0] clocks spent in slot; act[0..3] and sh[0..3] 4-bit weights.
//  - Reset (next edge): act=sh=WDEF; cur=0; cnt=0; lmix=rmix=8'h00; frame=0. Mid-slot reset aborts the slot.
//  - Slot length: act[cur] clocks. Each clock, if cnt < act[cur]-1 then cnt++.
//    Else advance: cnt=0; cur = next index above cur with act!=0.
//  - Frame end: the advance search passes index 3 (wraps). In that clock: act<=sh; frame=1; cur = lowest
//    index with sh!=0, chosen from the NEW weights.
//  - Weight 0 = source skipped (muted). A source is never selected with act==0.
//  - All-idle: if all act are 0, then lmix=rmix=0; act<=sh every clock; frame=1 every clock.
//    Leave all-idle on the first clock where sh has a nonzero weight.
//  - Mix (1 clock latency after cur), the same mapping as the fixed mixer:
//    0: L=R={1'b0,{7{speaker}}}   1: L=R=specdrum   2: L=a, R=b   3: L=R=c
//  - Config: cfgWe writes sh[cfgA]<=cfgD[3:0]; act is untouched until the next frame end.
//  - A write in the same clock as a commit: the commit takes the pre-write sh.
//    The new value is committed at the following frame end.
//  - Back-to-back writes: every clock is accepted; a later write to the same index wins.
// STRUCTURE
//  - Shared package audio_pkg: SRC_SPK=0, SRC_DRUM=1, SRC_AB=2, SRC_C=3; weight width 4; WDEF.
//  - One natural sub-module: audio_next_src, combinational priority search (act, cur) -> {next, wrap, none}.
//  - The top contains the weight regs, slot counter, commit logic and mix registers.
//  - The existing dac instances stay outside, driven by lmix/rmix.
// TESTING
//  1. Reset; speaker=1, specdrum=40, a=11, b=22, c=33.
//     -> lmix 7F,40,11,33 repeating; rmix 7F,40,22,33; frame every 4 clocks.
//  2. Write weights 3,0,1,2 mid-frame -> output unchanged until the frame pulse.
//     Then lmix 7F,7F,7F,11,33,33 with period 6; frame every 6 clocks.
//  3. Write all weights 0 -> after commit lmix=rmix=00, frame high every clock.
//     Write sh[1]=1 -> next clock lmix=rmix=40 continuously.
//  4. Write sh[2]=5 in the exact clock of a frame pulse -> the next frame still uses the old weight.
//     The frame after that has 5 consecutive a/b clocks.
//  5. Weight 15 on source 0; assert reset for 1 clock at cnt=7.
//     -> next clock lmix=00, frame=0; then the 7F,40,11,33 rotation resumes.
//  6. Write each sh[i]=i+4, cfgA sweep -> cfgQ reads 04,05,06,07; upper data bits ignored (cfgD=F9 reads 09).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio slot scheduler.
package audio_pkg;

    localparam int unsigned NSRC  = 4;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned WW    = 4;
    localparam int unsigned MIX_W = 8;

    localparam logic [WW-1:0] WDEF = 4'd1;

    typedef enum logic [SRC_W-1:0] {
        SRC_SPK  = 2'd0,
        SRC_DRUM = 2'd1,
        SRC_AB   = 2'd2,
        SRC_C    = 2'd3
    } src_e;

    typedef logic [NSRC-1:0][WW-1:0] weights_t;

    typedef struct packed {
        logic [MIX_W-1:0] l;
        logic [MIX_W-1:0] r;
    } mix_t;

endpackage

// File: rtl/audio_next_src.sv
// Priority search: first source above i_cur with a nonzero weight, else the lowest
// nonzero source overall (o_wrap_c set). o_none_c flags an all-zero weight set.
module audio_next_src
    import audio_pkg::*;
(
    input  logic [NSRC-1:0][WW-1:0] i_wgt,
    input  logic [SRC_W-1:0]        i_cur,
    output logic [SRC_W-1:0]        o_next_c,
    output logic                    o_wrap_c,
    output logic                    o_none_c
);

    always_comb begin
        o_next_c = '0;
        o_wrap_c = 1'b1;
        o_none_c = 1'b1;
        // Descending scans so the lowest qualifying index is written last.
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (i_wgt[SRC_W'(i)] != '0) begin
                o_none_c = 1'b0;
                o_next_c = SRC_W'(i);
            end
        end
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if ((i > int'(i_cur)) && (i_wgt[SRC_W'(i)] != '0)) begin
                o_wrap_c = 1'b0;
                o_next_c = SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/audio_slot_scheduler.sv
// Weighted time-slot scheduler feeding the shared L/R audio DACs. Shadow weights
// are written through the config port and become active at each frame end.
module audio_slot_scheduler #(
    parameter logic [3:0] WDEF = audio_pkg::WDEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       speaker,
    input  logic [7:0] specdrum,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic       cfgWe,
    input  logic [1:0] cfgA,
    input  logic [7:0] cfgD,
    output logic [7:0] cfgQ,
    output logic [7:0] lmix,
    output logic [7:0] rmix,
    output logic       frame
);

    import audio_pkg::*;

    weights_t         r_act;
    weights_t         r_sh;
    logic [SRC_W-1:0] r_cur;
    logic [WW-1:0]    r_cnt;
    logic [MIX_W-1:0] r_lmix;
    logic [MIX_W-1:0] r_rmix;
    logic             r_frame;

    logic [SRC_W-1:0] w_adv_next;
    logic             w_adv_wrap;
    logic             w_idle;
    logic [SRC_W-1:0] w_first;
    logic             w_slot_more;
    mix_t             w_mix;
    logic             w_unused_first_wrap;
    logic             w_unused_first_none;
    logic             w_unused_cfg;

    audio_next_src u_adv (
        .i_wgt    (r_act),
        .i_cur    (r_cur),
        .o_next_c (w_adv_next),
        .o_wrap_c (w_adv_wrap),
        .o_none_c (w_idle)
    );

    // Searching above the last index always wraps, yielding the lowest nonzero shadow weight.
    audio_next_src u_first (
        .i_wgt    (r_sh),
        .i_cur    (SRC_W'(NSRC - 1)),
        .o_next_c (w_first),
        .o_wrap_c (w_unused_first_wrap),
        .o_none_c (w_unused_first_none)
    );

    assign w_slot_more  = (5'(r_cnt) + 5'd1) < 5'(r_act[r_cur]);
    assign w_unused_cfg = ^cfgD[MIX_W-1:WW];

    always_comb begin
        w_mix = '0;
        case (src_e'(r_cur))
            SRC_SPK: begin
                w_mix.l = {1'b0, {7{speaker}}};
                w_mix.r = {1'b0, {7{speaker}}};
            end
            SRC_DRUM: begin
                w_mix.l = specdrum;
                w_mix.r = specdrum;
            end
            SRC_AB: begin
                w_mix.l = a;
                w_mix.r = b;
            end
            SRC_C: begin
                w_mix.l = c;
                w_mix.r = c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_act   <= {NSRC{WDEF}};
            r_sh    <= {NSRC{WDEF}};
            r_cur   <= '0;
            r_cnt   <= '0;
            r_lmix  <= '0;
            r_rmix  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (cfgWe) begin
                r_sh[cfgA] <= cfgD[WW-1:0];
            end
            if (w_idle) begin
                // Nothing active: silence and retry the commit every clock.
                r_act   <= r_sh;
                r_frame <= 1'b1;
                r_cur   <= w_first;
                r_cnt   <= '0;
                r_lmix  <= '0;
                r_rmix  <= '0;
            end else begin
                r_lmix <= w_mix.l;
                r_rmix <= w_mix.r;
                if (w_slot_more) begin
                    r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_cnt <= '0;
                    if (w_adv_wrap) begin
                        r_act   <= r_sh;
                        r_frame <= 1'b1;
                        r_cur   <= w_first;
                    end else begin
                        r_cur <= w_adv_next;
                    end
                end
            end
        end
    end

    assign cfgQ  = {{(MIX_W - WW){1'b0}}, r_sh[cfgA]};
    assign lmix  = r_lmix;
    assign rmix  = r_rmix;
    assign frame = r_frame;

endmodule
